// File: rtl/fibre_a_spike_buffer_pkg.sv
// rtl/fibre_a_spike_buffer_pkg.sv - shared bank-state type and depth helper for the fibre_a spike buffer
package fibre_a_spike_buffer_pkg;

   typedef enum logic [1:0] {
      B_FREE = 2'd0,
      B_FILL = 2'd1,
      B_FULL = 2'd2
   } bank_state_e;

   function automatic int depth_of(input int addr_width);
      return 1 << addr_width;
   endfunction

endpackage

// File: rtl/fibre_a_bank_ram.sv
// rtl/fibre_a_bank_ram.sv - one spike bank: single write port, registered read port
module fibre_a_bank_ram
   import fibre_a_spike_buffer_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  we_i,
   input  logic [ADDR_WIDTH-1:0] waddr_i,
   input  logic [WIDTH-1:0]      wdata_i,
   input  logic                  re_i,
   input  logic [ADDR_WIDTH-1:0] raddr_i,
   output logic [WIDTH-1:0]      rdata_o
);

   localparam int DEPTH = depth_of(ADDR_WIDTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
      if (re_i) rdata_q <= mem_q[raddr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/fibre_a_spike_buffer.sv
// rtl/fibre_a_spike_buffer.sv - ping-pong spike-train store serving the TPPE fibre_a read port
// Optional FIBRE_A_PARITY_EN adds a per-entry even-parity bit and the parity_err output.
module fibre_a_spike_buffer
   import fibre_a_spike_buffer_pkg::*;
#(
   parameter int TIMESTEPS  = 8,
   parameter int ADDR_WIDTH = 8,
   parameter int CNT_WIDTH  = ADDR_WIDTH + 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [TIMESTEPS-1:0]  wr_data,
   input  logic                  wr_last,
   output logic                  load_ready,
   input  logic [ADDR_WIDTH-1:0] fibre_a_addr,
   input  logic                  fibre_a_read_en,
   output logic [TIMESTEPS-1:0]  fibre_a_data,
   output logic                  fibre_a_valid,
   input  logic                  rd_release,
   output logic                  read_ready,
   output logic [CNT_WIDTH-1:0]  fill_count,
   output logic                  wr_overflow,
   output logic                  rd_underflow
`ifdef FIBRE_A_PARITY_EN
   ,
   output logic                  parity_err
`endif
);

`ifdef FIBRE_A_PARITY_EN
   localparam int RAM_W = TIMESTEPS + 1;
`else
   localparam int RAM_W = TIMESTEPS;
`endif

   bank_state_e          state_q [2];
   bank_state_e          state_d [2];
   logic [CNT_WIDTH-1:0] count_q [2];
   logic [CNT_WIDTH-1:0] count_d [2];
   logic                 wb_q, wb_d, rb_q, rb_d;
   logic                 valid_q, valid_d, pad_q, pad_d, rsel_q, rsel_d;
   logic                 ovf_q, ovf_d, udf_q, udf_d;

   logic                 wr_acc, commit, release_acc, rd_acc;
   logic [CNT_WIDTH-1:0] wr_end;
   logic [RAM_W-1:0]     wword, rdata0, rdata1, rword;

   assign load_ready  = (state_q[wb_q] != B_FULL);
   assign read_ready  = (state_q[rb_q] == B_FULL);
   assign wr_acc      = wr_en && load_ready;
   assign commit      = wr_last && load_ready;
   assign release_acc = rd_release && read_ready;
   assign rd_acc      = fibre_a_read_en && read_ready;
   assign wr_end      = CNT_WIDTH'(wr_addr) + CNT_WIDTH'(1);

`ifdef FIBRE_A_PARITY_EN
   assign wword = {^wr_data, wr_data};
`else
   assign wword = wr_data;
`endif

   // Commit only targets a non-FULL wb bank and release only a FULL rb bank, so they never collide.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      wb_d    = wb_q;
      rb_d    = rb_q;
      if (wr_acc) begin
         if (count_q[wb_q] < wr_end) count_d[wb_q] = wr_end;
         if (state_q[wb_q] == B_FREE) state_d[wb_q] = B_FILL;
      end
      if (commit) begin
         state_d[wb_q] = B_FULL;
         wb_d          = ~wb_q;
      end
      if (release_acc) begin
         state_d[rb_q] = B_FREE;
         count_d[rb_q] = '0;
         rb_d          = ~rb_q;
      end
   end

   always_comb begin
      valid_d = rd_acc;
      pad_d   = !(CNT_WIDTH'(fibre_a_addr) < count_q[rb_q]);
      rsel_d  = rb_q;
      ovf_d   = ovf_q || ((wr_en || wr_last) && !load_ready);
      udf_d   = udf_q || (fibre_a_read_en && !read_ready);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= '{B_FREE, B_FREE};
         count_q <= '{'0, '0};
         wb_q    <= 1'b0;
         rb_q    <= 1'b0;
         valid_q <= 1'b0;
         pad_q   <= 1'b0;
         rsel_q  <= 1'b0;
         ovf_q   <= 1'b0;
         udf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         wb_q    <= wb_d;
         rb_q    <= rb_d;
         valid_q <= valid_d;
         pad_q   <= pad_d;
         rsel_q  <= rsel_d;
         ovf_q   <= ovf_d;
         udf_q   <= udf_d;
      end
   end

   fibre_a_bank_ram #(.WIDTH(RAM_W), .ADDR_WIDTH(ADDR_WIDTH)) u_bank0 (
      .clk     (clk),
      .we_i    (wr_acc && !wb_q),
      .waddr_i (wr_addr),
      .wdata_i (wword),
      .re_i    (rd_acc && !rb_q),
      .raddr_i (fibre_a_addr),
      .rdata_o (rdata0)
   );

   fibre_a_bank_ram #(.WIDTH(RAM_W), .ADDR_WIDTH(ADDR_WIDTH)) u_bank1 (
      .clk     (clk),
      .we_i    (wr_acc && wb_q),
      .waddr_i (wr_addr),
      .wdata_i (wword),
      .re_i    (rd_acc && rb_q),
      .raddr_i (fibre_a_addr),
      .rdata_o (rdata1)
   );

   // Stale RAM contents beyond the committed count are masked to zero here.
   assign rword         = rsel_q ? rdata1 : rdata0;
   assign fibre_a_valid = valid_q;
   assign fibre_a_data  = (valid_q && !pad_q) ? rword[TIMESTEPS-1:0] : '0;
   assign fill_count    = read_ready ? count_q[rb_q] : '0;
   assign wr_overflow   = ovf_q;
   assign rd_underflow  = udf_q;

`ifdef FIBRE_A_PARITY_EN
   assign parity_err = valid_q && !pad_q && (^rword);
`endif

endmodule

// File: tb/tb_fibre_a_spike_buffer.sv
// tb/tb_fibre_a_spike_buffer.sv - directed self-checking bench for fibre_a_spike_buffer
module tb_fibre_a_spike_buffer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       wr_en = 1'b0;
   logic [7:0] wr_addr = '0;
   logic [7:0] wr_data = '0;
   logic       wr_last = 1'b0;
   logic       load_ready;
   logic [7:0] fibre_a_addr = '0;
   logic       fibre_a_read_en = 1'b0;
   logic [7:0] fibre_a_data;
   logic       fibre_a_valid;
   logic       rd_release = 1'b0;
   logic       read_ready;
   logic [8:0] fill_count;
   logic       wr_overflow;
   logic       rd_underflow;
`ifdef FIBRE_A_PARITY_EN
   logic       parity_err;
`endif

   int checks = 0;
   int errors = 0;

   fibre_a_spike_buffer dut (
      .clk             (clk),
      .rst             (rst),
      .wr_en           (wr_en),
      .wr_addr         (wr_addr),
      .wr_data         (wr_data),
      .wr_last         (wr_last),
      .load_ready      (load_ready),
      .fibre_a_addr    (fibre_a_addr),
      .fibre_a_read_en (fibre_a_read_en),
      .fibre_a_data    (fibre_a_data),
      .fibre_a_valid   (fibre_a_valid),
      .rd_release      (rd_release),
      .read_ready      (read_ready),
      .fill_count      (fill_count),
      .wr_overflow     (wr_overflow),
      .rd_underflow    (rd_underflow)
`ifdef FIBRE_A_PARITY_EN
      ,
      .parity_err      (parity_err)
`endif
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic write(input logic [7:0] a, input logic [7:0] d, input logic last);
      wr_en = 1'b1; wr_addr = a; wr_data = d; wr_last = last;
      tick();
      wr_en = 1'b0; wr_last = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      tick();
      tick();
      checks++; if (fibre_a_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", fibre_a_valid); end
      checks++; if (read_ready !== 1'b0) begin errors++; $display("FAIL reset_read_ready got %0b exp 0", read_ready); end
      checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL reset_load_ready got %0b exp 1", load_ready); end
      checks++; if (fill_count !== 9'd0) begin errors++; $display("FAIL reset_fill_count got %0d exp 0", fill_count); end
      checks++; if ({wr_overflow, rd_underflow} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b exp 00", {wr_overflow, rd_underflow}); end
      rst = 1'b0;
   endtask

   task automatic test_underflow;
      fibre_a_read_en = 1'b1; fibre_a_addr = 8'd0;
      tick();
      fibre_a_read_en = 1'b0;
      checks++; if (fibre_a_valid !== 1'b0) begin errors++; $display("FAIL udf_valid got %0b exp 0", fibre_a_valid); end
      checks++; if (fibre_a_data !== 8'h00) begin errors++; $display("FAIL udf_data got %h exp 00", fibre_a_data); end
      checks++; if (rd_underflow !== 1'b1) begin errors++; $display("FAIL udf_flag got %0b exp 1", rd_underflow); end
      tick();
      checks++; if (rd_underflow !== 1'b1) begin errors++; $display("FAIL udf_sticky got %0b exp 1", rd_underflow); end
   endtask

   task automatic test_fill_read;
      write(8'd0, 8'hA5, 1'b0);
      write(8'd1, 8'h3C, 1'b0);
      write(8'd2, 8'h00, 1'b0);
      write(8'd3, 8'hFF, 1'b0);
      checks++; if (read_ready !== 1'b0) begin errors++; $display("FAIL fill_pre_commit_ready got %0b exp 0", read_ready); end
      wr_last = 1'b1;
      tick();
      wr_last = 1'b0;
      checks++; if (read_ready !== 1'b1) begin errors++; $display("FAIL fill_read_ready got %0b exp 1", read_ready); end
      checks++; if (fill_count !== 9'd4) begin errors++; $display("FAIL fill_count got %0d exp 4", fill_count); end
      checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL fill_load_ready got %0b exp 1", load_ready); end
      fibre_a_read_en = 1'b1; fibre_a_addr = 8'd1;
      tick();
      checks++; if ({fibre_a_valid, fibre_a_data} !== {1'b1, 8'h3C}) begin errors++; $display("FAIL rd_addr1 got v=%0b d=%h exp v=1 d=3c", fibre_a_valid, fibre_a_data); end
      fibre_a_addr = 8'd3;
      tick();
      checks++; if ({fibre_a_valid, fibre_a_data} !== {1'b1, 8'hFF}) begin errors++; $display("FAIL rd_addr3 got v=%0b d=%h exp v=1 d=ff", fibre_a_valid, fibre_a_data); end
      fibre_a_read_en = 1'b0;
      tick();
      checks++; if (fibre_a_valid !== 1'b0) begin errors++; $display("FAIL rd_valid_drop got %0b exp 0", fibre_a_valid); end
      fibre_a_read_en = 1'b1; fibre_a_addr = 8'd10;
      tick();
      fibre_a_read_en = 1'b0;
      checks++; if ({fibre_a_valid, fibre_a_data} !== {1'b1, 8'h00}) begin errors++; $display("FAIL rd_pad got v=%0b d=%h exp v=1 d=00", fibre_a_valid, fibre_a_data); end
      rd_release = 1'b1;
      tick();
      rd_release = 1'b0;
      checks++; if ({read_ready, fill_count} !== {1'b0, 9'd0}) begin errors++; $display("FAIL release_state got rr=%0b cnt=%0d exp rr=0 cnt=0", read_ready, fill_count); end
   endtask

   task automatic test_full_overflow;
      write(8'd0, 8'h11, 1'b1);
      checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL tileA_load_ready got %0b exp 1", load_ready); end
      write(8'd0, 8'h22, 1'b1);
      checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL both_full_load_ready got %0b exp 0", load_ready); end
      checks++; if (wr_overflow !== 1'b0) begin errors++; $display("FAIL ovf_early got %0b exp 0", wr_overflow); end
      write(8'd0, 8'h99, 1'b0);
      checks++; if (wr_overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %0b exp 1", wr_overflow); end
      fibre_a_read_en = 1'b1; fibre_a_addr = 8'd0;
      tick();
      fibre_a_read_en = 1'b0;
      checks++; if ({fibre_a_valid, fibre_a_data} !== {1'b1, 8'h11}) begin errors++; $display("FAIL tileA_data got v=%0b d=%h exp v=1 d=11", fibre_a_valid, fibre_a_data); end
      rd_release = 1'b1;
      tick();
      rd_release = 1'b0;
      checks++; if ({load_ready, read_ready, fill_count} !== {1'b1, 1'b1, 9'd1}) begin errors++; $display("FAIL after_release got lr=%0b rr=%0b cnt=%0d exp lr=1 rr=1 cnt=1", load_ready, read_ready, fill_count); end
      fibre_a_read_en = 1'b1;
      tick();
      fibre_a_read_en = 1'b0;
      checks++; if ({fibre_a_valid, fibre_a_data} !== {1'b1, 8'h22}) begin errors++; $display("FAIL tileB_data got v=%0b d=%h exp v=1 d=22", fibre_a_valid, fibre_a_data); end
      checks++; if (wr_overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %0b exp 1", wr_overflow); end
   endtask

   task automatic test_same_cycle;
      write(8'd0, 8'h33, 1'b0);
      fibre_a_read_en = 1'b1; fibre_a_addr = 8'd0; rd_release = 1'b1; wr_last = 1'b1;
      tick();
      rd_release = 1'b0; wr_last = 1'b0;
      checks++; if ({fibre_a_valid, fibre_a_data} !== {1'b1, 8'h22}) begin errors++; $display("FAIL same_old_data got v=%0b d=%h exp v=1 d=22", fibre_a_valid, fibre_a_data); end
      checks++; if ({load_ready, read_ready, fill_count} !== {1'b1, 1'b1, 9'd1}) begin errors++; $display("FAIL same_state got lr=%0b rr=%0b cnt=%0d exp lr=1 rr=1 cnt=1", load_ready, read_ready, fill_count); end
      tick();
      checks++; if ({fibre_a_valid, fibre_a_data} !== {1'b1, 8'h33}) begin errors++; $display("FAIL tileC_data got v=%0b d=%h exp v=1 d=33", fibre_a_valid, fibre_a_data); end
      fibre_a_read_en = 1'b0;
   endtask

   task automatic test_reset_midstream;
      wr_last = 1'b1;
      tick();
      wr_last = 1'b0;
      checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL empty_commit_full got %0b exp 0", load_ready); end
      fibre_a_read_en = 1'b1; fibre_a_addr = 8'd0;
      tick();
      checks++; if ({fibre_a_valid, fibre_a_data} !== {1'b1, 8'h33}) begin errors++; $display("FAIL stream_data got v=%0b d=%h exp v=1 d=33", fibre_a_valid, fibre_a_data); end
      rst = 1'b1;
      tick();
      rst = 1'b0; fibre_a_read_en = 1'b0;
      checks++; if ({fibre_a_valid, read_ready, load_ready, fill_count} !== {1'b0, 1'b0, 1'b1, 9'd0}) begin errors++; $display("FAIL midrst_state got v=%0b rr=%0b lr=%0b cnt=%0d exp v=0 rr=0 lr=1 cnt=0", fibre_a_valid, read_ready, load_ready, fill_count); end
      checks++; if ({wr_overflow, rd_underflow} !== 2'b00) begin errors++; $display("FAIL midrst_flags got %b exp 00", {wr_overflow, rd_underflow}); end
   endtask

   task automatic test_empty_tile;
      wr_last = 1'b1;
      tick();
      wr_last = 1'b0;
      checks++; if ({read_ready, fill_count} !== {1'b1, 9'd0}) begin errors++; $display("FAIL empty_tile got rr=%0b cnt=%0d exp rr=1 cnt=0", read_ready, fill_count); end
      fibre_a_read_en = 1'b1; fibre_a_addr = 8'd1;
      tick();
      fibre_a_read_en = 1'b0;
      checks++; if ({fibre_a_valid, fibre_a_data} !== {1'b1, 8'h00}) begin errors++; $display("FAIL stale_mask got v=%0b d=%h exp v=1 d=00", fibre_a_valid, fibre_a_data); end
   endtask

`ifdef FIBRE_A_PARITY_EN
   task automatic test_parity;
      rd_release = 1'b1;
      tick();
      rd_release = 1'b0;
      write(8'd0, 8'h5A, 1'b0);
      write(8'd1, 8'h0F, 1'b1);
      dut.u_bank1.mem_q[0][0] = ~dut.u_bank1.mem_q[0][0];
      fibre_a_read_en = 1'b1; fibre_a_addr = 8'd0;
      tick();
      checks++; if ({fibre_a_valid, parity_err} !== 2'b11) begin errors++; $display("FAIL parity_bad got v=%0b pe=%0b exp v=1 pe=1", fibre_a_valid, parity_err); end
      fibre_a_addr = 8'd1;
      tick();
      fibre_a_read_en = 1'b0;
      checks++; if ({fibre_a_valid, parity_err, fibre_a_data} !== {2'b10, 8'h0F}) begin errors++; $display("FAIL parity_clean got v=%0b pe=%0b d=%h exp v=1 pe=0 d=0f", fibre_a_valid, parity_err, fibre_a_data); end
   endtask
`endif

   initial begin
      test_reset();
      test_underflow();
      test_fill_read();
      test_full_overflow();
      test_same_cycle();
      test_reset_midstream();
      test_empty_tile();
`ifdef FIBRE_A_PARITY_EN
      test_parity();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
